// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with valid/ready handshake, BCD adjust and bit-serial shifts.
module alu_multicycle #(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1,
  parameter int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             dec,
  input  logic [SHW-1:0]   shamt,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             v_out,
  output logic             z_out,
  output logic             n_out
);
  typedef enum logic [2:0] {IDLE, EXEC, ADJ, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic r_ci, r_dec, r_c, r_v, r_z, r_n, r_ov;
  logic [SHW-1:0] r_shamt, r_cnt;
  logic [WIDTH-1:0] w_bx, w_sum, w_res, w_zn, w_bcd_res;
  logic [WIDTH:0] w_full, w_sh;
  logic w_sub, w_cin, w_co, w_ovf, w_c, w_v, w_shift, w_bcd, w_dc;
  logic [4:0] w_t;

  // one bit of shift/rotate on the {carry, value} ring; k = op[1:0] of ASL/LSR/ROL/ROR
  function automatic logic [WIDTH:0] f_step(input logic [1:0] k, input logic [WIDTH-1:0] x, input logic c);
    case (k)
      2'd0:    f_step = {x[WIDTH-1], x[WIDTH-2:0], 1'b0};
      2'd1:    f_step = {x[0], 1'b0, x[WIDTH-1:1]};
      2'd2:    f_step = {x[WIDTH-1], x[WIDTH-2:0], c};
      default: f_step = {x[0], c, x[WIDTH-1:1]};
    endcase
  endfunction

  assign w_shift = r_op[3:2] == 2'b10;
  assign w_bcd   = DECIMAL_EN && r_dec && (r_op == 4'd4 || r_op == 4'd5);
  assign w_sub   = r_op == 4'd5 || r_op == 4'd12;
  assign w_bx    = w_sub ? ~r_b : r_b;
  assign w_cin   = r_op == 4'd12 ? 1'b1 : r_ci;
  assign w_full  = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_cin};
  assign w_sum   = w_full[WIDTH-1:0];
  assign w_co    = w_full[WIDTH];
  assign w_ovf   = (r_a[WIDTH-1] ^ w_sum[WIDTH-1]) & (w_bx[WIDTH-1] ^ w_sum[WIDTH-1]);
  assign w_sh    = f_step(r_op[1:0], r_res, r_c);
  assign w_zn    = r_op == 4'd12 ? w_sum : w_res;
  assign in_ready  = rst_n && r_state == IDLE;
  assign out_valid = r_ov;
  assign result    = r_res;
  assign c_out     = r_c;
  assign v_out     = r_v;
  assign z_out     = r_z;
  assign n_out     = r_n;

  always_comb begin
    w_res = r_a;
    w_c   = r_ci;
    w_v   = 1'b0;
    case (r_op)
      4'd1:                 w_res = r_a & r_b;
      4'd2:                 w_res = r_a | r_b;
      4'd3:                 w_res = r_a ^ r_b;
      4'd4, 4'd5:           {w_c, w_res, w_v} = {w_co, w_sum, w_ovf};
      4'd6:                 w_res = r_a + 1'b1;
      4'd7:                 w_res = r_a - 1'b1;
      4'd8, 4'd9, 4'd10, 4'd11: {w_c, w_res} = r_shamt == '0 ? {r_ci, r_a} : f_step(r_op[1:0], r_a, r_ci);
      4'd12:                w_c = w_co;
      default:              w_res = r_a;
    endcase
  end

  // decimal adjust, nibble by nibble with a chained decimal carry (SBC: 1 = no borrow)
  always_comb begin
    w_dc      = r_ci;
    w_bcd_res = '0;
    w_t       = '0;
    for (int i = 0; i < WIDTH / 4; i++) begin
      w_t = {1'b0, r_a[4*i+:4]} + {1'b0, w_bx[4*i+:4]} + {4'd0, w_dc};
      if (r_op == 4'd5) begin
        w_dc = w_t[4];
        w_bcd_res[4*i+:4] = w_t[4] ? w_t[3:0] : w_t[3:0] - 4'd6;
      end else begin
        w_dc = w_t > 5'd9;
        w_bcd_res[4*i+:4] = w_t > 5'd9 ? w_t[3:0] + 4'd6 : w_t[3:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? EXEC : IDLE;
      EXEC:    w_next = w_bcd ? ADJ : (w_shift && r_shamt > 1) ? SHIFT : DONE;
      ADJ:     w_next = DONE;
      SHIFT:   w_next = r_cnt == 1 ? DONE : SHIFT;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_op, r_a, r_b, r_ci, r_dec, r_shamt, r_cnt} <= '0;
      {r_res, r_c, r_v, r_z, r_n, r_ov} <= '0;
    end else begin
      r_ov <= w_next == DONE;
      if (!abort)
        case (r_state)
          IDLE: if (in_valid) {r_op, r_a, r_b, r_ci, r_dec, r_shamt} <= {op, a, b, ci, dec, shamt};
          EXEC: begin
            {r_res, r_c, r_v} <= {w_res, w_c, w_v};
            {r_z, r_n} <= {w_zn == '0, w_zn[WIDTH-1]};
            r_cnt <= r_shamt - 1'b1;
          end
          ADJ: {r_res, r_c, r_z, r_n} <= {w_bcd_res, w_dc, w_bcd_res == '0, w_bcd_res[WIDTH-1]};
          SHIFT: begin
            {r_c, r_res} <= w_sh;
            {r_z, r_n} <= {w_sh[WIDTH-1:0] == '0, w_sh[WIDTH-1]};
            r_cnt <= r_cnt - 1'b1;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors against a behavioural ALU model plus literal expectations.
module tb_alu_multicycle;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_valid2 = 0, ci = 0, dec = 0, abort = 0, out_ready = 0, out_ready2 = 0;
  logic [3:0] op = 0;
  logic [7:0] a = 0, b = 0;
  logic [2:0] shamt = 0;
  logic in_ready, out_valid, c_out, v_out, z_out, n_out;
  logic in_ready2, out_valid2, c_out2, v_out2, z_out2, n_out2;
  logic [7:0] result, result2;
  int errors = 0, checks = 0;
  bit pending = 0;
  logic [7:0] exp_r;
  logic exp_c, exp_v, exp_z, exp_n;
  int exp_lat;

  alu_multicycle #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .ci(ci), .dec(dec), .shamt(shamt), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .v_out(v_out), .z_out(z_out), .n_out(n_out));

  alu_multicycle #(.WIDTH(8), .DECIMAL_EN(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op), .a(a), .b(b),
    .ci(ci), .dec(dec), .shamt(shamt), .abort(1'b0), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .c_out(c_out2), .v_out(v_out2), .z_out(z_out2), .n_out(n_out2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2i(input logic [7:0] x);
    return int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int x);
    logic [7:0] t;
    t[7:4] = 4'(x / 10);
    t[3:0] = 4'(x % 10);
    return t;
  endfunction

  // reference behaviour in plain integer arithmetic
  task automatic model(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic xci,
                       input logic xd, input logic [2:0] xs, input bit den, output logic [7:0] r,
                       output logic c, output logic v, output logic z, output logic n, output int lat);
    int s, sa, sb, ic;
    logic [7:0] d;
    logic [8:0] ring;
    ic = int'(xci);
    r = xa; c = xci; v = 0; lat = 1; d = xa;
    sa = xa[7] ? int'(xa) - 256 : int'(xa);
    sb = xb[7] ? int'(xb) - 256 : int'(xb);
    case (o)
      4'd1: r = xa & xb;
      4'd2: r = xa | xb;
      4'd3: r = xa ^ xb;
      4'd4, 4'd5: begin
        s = o == 4'd4 ? int'(xa) + int'(xb) + ic : int'(xa) - int'(xb) - (1 - ic);
        r = s[7:0];
        c = o == 4'd4 ? s > 255 : s >= 0;
        s = o == 4'd4 ? sa + sb + ic : sa - sb - (1 - ic);
        v = s < -128 || s > 127;
        if (xd && den) begin
          s = o == 4'd4 ? bcd2i(xa) + bcd2i(xb) + ic : bcd2i(xa) - bcd2i(xb) - (1 - ic);
          c = o == 4'd4 ? s > 99 : s >= 0;
          r = i2bcd((s + 100) % 100);
          lat = 2;
        end
      end
      4'd6: r = xa + 8'd1;
      4'd7: r = xa - 8'd1;
      4'd8, 4'd9, 4'd10, 4'd11: begin
        ring = {xci, xa};
        repeat (int'(xs))
          case (o)
            4'd8:    ring = {ring[7], ring[6:0], 1'b0};
            4'd9:    ring = {ring[0], 1'b0, ring[7:1]};
            4'd10:   ring = {ring[7:0], ring[8]};
            default: ring = {ring[0], ring[8:1]};
          endcase
        {c, r} = ring;
        lat = xs == 0 ? 1 : int'(xs);
      end
      4'd12: begin
        s = int'(xa) - int'(xb);
        c = s >= 0;
        d = s[7:0];
      end
      default: r = xa;
    endcase
    if (o != 4'd12) d = r;
    z = d == 0;
    n = d[7];
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (pending && out_valid) begin
        chk("model_result", result, exp_r);
        chk("model_c", c_out, exp_c);
        chk("model_v", v_out, exp_v);
        chk("model_z", z_out, exp_z);
        chk("model_n", n_out, exp_n);
      end else if (!pending) chk("spurious_valid", out_valid, 0);
    end

  task automatic run_op(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic xci,
                        input logic xd, input logic [2:0] xs, input int hold, input logic [7:0] er,
                        input logic ec, input int elat);
    int n;
    op = o; a = xa; b = xb; ci = xci; dec = xd; shamt = xs; in_valid = 1;
    model(o, xa, xb, xci, xd, xs, 1'b1, exp_r, exp_c, exp_v, exp_z, exp_n, exp_lat);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; pending = 1;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, elat);
    chk("latency_model", n, exp_lat);
    chk("result_lit", result, er);
    chk("c_lit", c_out, ec);
    repeat (hold) begin
      in_valid = 1;
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; pending = 0;
    chk("consumed", out_valid, 0);
    chk("idle_ready", in_ready, 1);
  endtask

  typedef struct {logic [3:0] o; logic [7:0] a, b; logic c, d; logic [2:0] s; logic [7:0] r; logic rc; int lat;} vec_t;
  vec_t vecs[12] = '{
    '{4'd1, 8'hF0, 8'h3C, 1'b1, 1'b0, 3'd0, 8'h30, 1'b1, 1},
    '{4'd2, 8'h0F, 8'h30, 1'b0, 1'b0, 3'd0, 8'h3F, 1'b0, 1},
    '{4'd3, 8'hFF, 8'h0F, 1'b1, 1'b0, 3'd0, 8'hF0, 1'b1, 1},
    '{4'd6, 8'hFF, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1},
    '{4'd7, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'hFF, 1'b1, 1},
    '{4'd5, 8'h10, 8'h20, 1'b1, 1'b0, 3'd0, 8'hF0, 1'b0, 1},
    '{4'd8, 8'h81, 8'h00, 1'b0, 1'b0, 3'd7, 8'h80, 1'b0, 7},
    '{4'd11, 8'h01, 8'h00, 1'b0, 1'b0, 3'd4, 8'h20, 1'b0, 4},
    '{4'd9, 8'h06, 8'h00, 1'b0, 1'b0, 3'd2, 8'h01, 1'b1, 2},
    '{4'd4, 8'h99, 8'h01, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 2},
    '{4'd5, 8'h00, 8'h01, 1'b1, 1'b1, 3'd0, 8'h99, 1'b0, 2},
    '{4'd12, 8'h10, 8'h20, 1'b0, 1'b0, 3'd0, 8'h10, 1'b0, 1}};

  initial begin
    int n;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {c_out, v_out, z_out, n_out}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1 chk("post_rst_ready", in_ready, 1);

    run_op(4'd4, 8'h50, 8'h50, 1'b0, 1'b0, 3'd0, 0, 8'hA0, 1'b0, 1);
    chk("adc_vzn", {v_out, z_out, n_out}, 3'b101);
    run_op(4'd4, 8'h58, 8'h46, 1'b1, 1'b1, 3'd0, 0, 8'h05, 1'b1, 2);
    run_op(4'd5, 8'h12, 8'h21, 1'b1, 1'b1, 3'd0, 0, 8'h91, 1'b0, 2);
    chk("sbcd_n", n_out, 1);
    run_op(4'd12, 8'h40, 8'h40, 1'b0, 1'b0, 3'd0, 0, 8'h40, 1'b1, 1);
    chk("cmp_z", z_out, 1);
    run_op(4'd10, 8'h81, 8'h00, 1'b1, 1'b0, 3'd3, 0, 8'h0E, 1'b0, 3);
    run_op(4'd9, 8'h01, 8'h00, 1'b1, 1'b0, 3'd0, 0, 8'h01, 1'b1, 1);
    run_op(4'd3, 8'hA5, 8'h5A, 1'b1, 1'b0, 3'd0, 5, 8'hFF, 1'b1, 1);
    foreach (vecs[i])
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].s, 0, vecs[i].r, vecs[i].rc, vecs[i].lat);

    op = 4'd4; a = 8'h58; b = 8'h46; ci = 1; dec = 1; shamt = 0; in_valid2 = 1;
    chk("nodec_ready", in_ready2, 1);
    @(posedge clk); #1;
    in_valid2 = 0;
    n = 0;
    while (!out_valid2 && n < 20) begin @(posedge clk); #1; n++; end
    chk("nodec_latency", n, 1);
    chk("nodec_result", result2, 8'h9F);
    chk("nodec_cvzn", {c_out2, v_out2, z_out2, n_out2}, 4'b0101);
    out_ready2 = 1;
    @(posedge clk); #1;
    out_ready2 = 0;
    chk("nodec_consumed", out_valid2, 0);

    op = 4'd8; a = 8'h01; ci = 0; dec = 0; shamt = 3'd5; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    abort = 1; out_ready = 1;
    @(posedge clk); #1;
    abort = 0; out_ready = 0;
    chk("abort_idle", in_ready, 1);
    chk("abort_result_kept", result, 8'h04);
    chk("abort_c_kept", c_out, 0);
    repeat (8) @(posedge clk);
    #1;

    op = 4'd4; a = 8'h58; b = 8'h46; ci = 1; dec = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {c_out, v_out, z_out, n_out}, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1;
    run_op(4'd1, 8'hFF, 8'h0F, 1'b0, 1'b0, 3'd0, 0, 8'h0F, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
